// File: rtl/pi_step_initiator.sv
// Purpose : step sequencer for the PI sta/done_read_x/done_sig handshake; latches x, starts the PI, captures y.
// Latency : step -> done_read_x 1 cycle; done_read_x -> sta LEAD cycles; done_sig_pi -> y_valid 1 cycle.
// Backpr. : none; a step arriving while busy is dropped and flagged in the sticky overrun bit.
//
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-low reset
//   step, x_in        : time-step tick and the sample that accompanies it (sampled only in IDLE)
//   clear_req         : integrator clear request; also clears overrun/err (deferred while busy)
//   x, done_read_x    : held sample to the PI and its one-cycle announce pulse
//   sta, rst_user     : one-cycle PI start and integrator-clear pulses
//   y_pi, done_sig_pi : PI result and completion pulse
//   y_hold, y_valid   : last captured result and its one-cycle update pulse
//   busy, overrun, err: not-IDLE status, sticky dropped-step flag, sticky timeout flag
//
// Build option: define PI_STEP_WATCHDOG_EN to enable the TIMEOUT watchdog in WAIT;
// without it WAIT waits indefinitely and err is tied low.

module pi_step_initiator #(
   parameter int WIDTH   = 32,
   parameter int LEAD    = 15,
   parameter int TIMEOUT = 63
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic [WIDTH-1:0] x_in,
   input  logic             clear_req,
   output logic [WIDTH-1:0] x,
   output logic             done_read_x,
   output logic             sta,
   output logic             rst_user,
   input  logic [WIDTH-1:0] y_pi,
   input  logic             done_sig_pi,
   output logic [WIDTH-1:0] y_hold,
   output logic             y_valid,
   output logic             busy,
   output logic             overrun,
   output logic             err
);

   localparam int CNT_MAX = (LEAD > TIMEOUT) ? LEAD : TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   // Loaded on entry to LEAD; sta is issued in the cycle the counter reads zero,
   // which places it exactly LEAD cycles after the done_read_x pulse.
   localparam logic [CW-1:0] LEAD_LOAD = CW'(LEAD - 1);

`ifdef PI_STEP_WATCHDOG_EN
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};
`endif

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LEAD    = 2'd1,
      S_WAIT    = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_x,           w_x_nxt;
   logic [WIDTH-1:0] r_y_hold,      w_y_hold_nxt;
   logic             r_done_read_x, w_done_read_x_nxt;
   logic             r_sta,         w_sta_nxt;
   logic             r_rst_user,    w_rst_user_nxt;
   logic             r_y_valid,     w_y_valid_nxt;
   logic             r_busy,        w_busy_nxt;
   logic             r_overrun,     w_overrun_nxt;
   logic             r_clr_pend,    w_clr_pend_nxt;
   logic [CW-1:0]    r_lead_cnt,    w_lead_cnt_nxt;
   logic             w_to_idle;
   logic             w_done_ok;

`ifdef PI_STEP_WATCHDOG_EN
   logic             r_err,         w_err_nxt;
   logic [CW-1:0]    r_wd_cnt,      w_wd_cnt_nxt;
   logic             w_err_set;
`endif

   // sta is high only in the first WAIT cycle, so masking with it drops a
   // done_sig_pi that coincides with the start pulse.
   assign w_done_ok = done_sig_pi & ~r_sta;

   //------------------------------------------------------------------
   // Next-state / next-output logic
   //------------------------------------------------------------------
   always_comb begin
      w_state_nxt       = r_state;
      w_x_nxt           = r_x;
      w_y_hold_nxt      = r_y_hold;
      w_done_read_x_nxt = 1'b0;
      w_sta_nxt         = 1'b0;
      w_rst_user_nxt    = 1'b0;
      w_y_valid_nxt     = 1'b0;
      w_overrun_nxt     = r_overrun;
      w_clr_pend_nxt    = r_clr_pend;
      w_lead_cnt_nxt    = r_lead_cnt;
      w_to_idle         = 1'b0;
`ifdef PI_STEP_WATCHDOG_EN
      w_err_nxt         = r_err;
      w_wd_cnt_nxt      = r_wd_cnt;
      w_err_set         = 1'b0;
`endif

      case (r_state)
         S_IDLE: begin
            // A clear in the same cycle as a step takes priority and the
            // step is silently dropped (not an overrun).
            if (clear_req) begin
               w_rst_user_nxt = 1'b1;
               w_overrun_nxt  = 1'b0;
`ifdef PI_STEP_WATCHDOG_EN
               w_err_nxt      = 1'b0;
`endif
            end else if (step) begin
               w_x_nxt           = x_in;
               w_done_read_x_nxt = 1'b1;
               w_lead_cnt_nxt    = LEAD_LOAD;
               w_state_nxt       = S_LEAD;
            end
         end

         S_LEAD: begin
            if (r_lead_cnt == '0) begin
               w_sta_nxt   = 1'b1;
               w_state_nxt = S_WAIT;
`ifdef PI_STEP_WATCHDOG_EN
               w_wd_cnt_nxt = '0;
`endif
            end else begin
               w_lead_cnt_nxt = r_lead_cnt - CW'(1);
            end
         end

         S_WAIT: begin
            if (w_done_ok) begin
               w_y_hold_nxt  = y_pi;
               w_y_valid_nxt = 1'b1;
               w_state_nxt   = S_CAPTURE;
            end
`ifdef PI_STEP_WATCHDOG_EN
            // Watchdog counts WAIT cycles from the sta cycle (count 0); err
            // becomes visible TIMEOUT cycles after sta.
            else if (r_wd_cnt == WD_LAST) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
               w_to_idle   = 1'b1;
            end else if (r_wd_cnt != CNT_SAT) begin
               w_wd_cnt_nxt = r_wd_cnt + CW'(1);
            end
`endif
         end

         S_CAPTURE: begin
            w_state_nxt = S_IDLE;
            w_to_idle   = 1'b1;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Busy-time side effects: defer clears to the first IDLE cycle, flag
      // dropped steps. A deferred clear fires on the edge that re-enters
      // IDLE so rst_user is visible during that first IDLE cycle.
      if (r_state != S_IDLE) begin
         if (clear_req) begin
            w_clr_pend_nxt = 1'b1;
         end
         if (w_to_idle && (r_clr_pend || clear_req)) begin
            w_rst_user_nxt = 1'b1;
            w_overrun_nxt  = 1'b0;
            w_clr_pend_nxt = 1'b0;
`ifdef PI_STEP_WATCHDOG_EN
            w_err_nxt      = 1'b0;
`endif
         end
         if (step) begin
            w_overrun_nxt = 1'b1;
         end
      end

`ifdef PI_STEP_WATCHDOG_EN
      // A timeout in the same cycle as a deferred clear still leaves err set:
      // the timeout is the newer event.
      if (w_err_set) begin
         w_err_nxt = 1'b1;
      end
`endif

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   //------------------------------------------------------------------
   // State and output registers
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_x           <= '0;
         r_y_hold      <= '0;
         r_done_read_x <= 1'b0;
         r_sta         <= 1'b0;
         r_rst_user    <= 1'b0;
         r_y_valid     <= 1'b0;
         r_busy        <= 1'b0;
         r_overrun     <= 1'b0;
         r_clr_pend    <= 1'b0;
         r_lead_cnt    <= '0;
`ifdef PI_STEP_WATCHDOG_EN
         r_err         <= 1'b0;
         r_wd_cnt      <= '0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_x           <= w_x_nxt;
         r_y_hold      <= w_y_hold_nxt;
         r_done_read_x <= w_done_read_x_nxt;
         r_sta         <= w_sta_nxt;
         r_rst_user    <= w_rst_user_nxt;
         r_y_valid     <= w_y_valid_nxt;
         r_busy        <= w_busy_nxt;
         r_overrun     <= w_overrun_nxt;
         r_clr_pend    <= w_clr_pend_nxt;
         r_lead_cnt    <= w_lead_cnt_nxt;
`ifdef PI_STEP_WATCHDOG_EN
         r_err         <= w_err_nxt;
         r_wd_cnt      <= w_wd_cnt_nxt;
`endif
      end
   end

   assign x           = r_x;
   assign y_hold      = r_y_hold;
   assign done_read_x = r_done_read_x;
   assign sta         = r_sta;
   assign rst_user    = r_rst_user;
   assign y_valid     = r_y_valid;
   assign busy        = r_busy;
   assign overrun     = r_overrun;
`ifdef PI_STEP_WATCHDOG_EN
   assign err         = r_err;
`else
   assign err         = 1'b0;
`endif

endmodule
